// File: rtl/grant_onehot_decoder.sv
// grant_onehot_decoder
//   Accepts an encoded grant (01/10/11 -> requester 0/1/2) when idle and
//   drives the matching one-hot grant until the requester releases it with
//   its req_done bit, or until the grant has been held for TIMEOUT cycles.
//   Illegal codes, stray release strobes and timeouts raise sticky error
//   flags that are cleared by err_clr.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   grant_valid   encoded grant offered this cycle
//   grant_code    encoded grant (00 is illegal)
//   grant_ready   high while idle, i.e. a grant can be accepted
//   req_done      per-requester release strobe
//   grant_onehot  registered one-hot grant
//   busy          a grant is currently held
//   hold_cnt      cycles elapsed in the current grant
//   err_clr       synchronous clear of the sticky error flags
//   err_illegal   sticky: code 00 was accepted
//   err_spurious  sticky: req_done seen on a bit that is not granted
//   err_timeout   sticky: a grant was forcibly released by timeout
module grant_onehot_decoder #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       grant_valid,
  input  logic [1:0] grant_code,
  output logic       grant_ready,
  input  logic [2:0] req_done,
  output logic [2:0] grant_onehot,
  output logic       busy,
  output logic [7:0] hold_cnt,
  input  logic       err_clr,
  output logic       err_illegal,
  output logic       err_spurious,
  output logic       err_timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [2:0] onehot_q, onehot_d;
  logic [7:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  logic       spurious_q, spurious_d;
  logic       timeout_q, timeout_d;

  logic       illegalSet;
  logic       spuriousSet;
  logic       timeoutSet;
  logic       doneMatch;
  logic [2:0] decoded;

  always_comb begin
    decoded = 3'b000;
    case (grant_code)
      2'b01:   decoded = 3'b001;
      2'b10:   decoded = 3'b010;
      2'b11:   decoded = 3'b100;
      default: decoded = 3'b000;
    endcase
  end

  assign doneMatch = |(req_done & onehot_q);

  always_comb begin
    state_d     = state_q;
    onehot_d    = onehot_q;
    cnt_d       = cnt_q;
    illegalSet  = 1'b0;
    spuriousSet = 1'b0;
    timeoutSet  = 1'b0;
    case (state_q)
      IDLE: begin
        spuriousSet = |req_done;
        if (grant_valid) begin
          if (grant_code == 2'b00) begin
            illegalSet = 1'b1;
          end else begin
            state_d  = HOLD;
            onehot_d = decoded;
            cnt_d    = 8'd0;
          end
        end
      end
      HOLD: begin
        // A stray bit flags an error, but a matching bit in the same
        // cycle still releases the grant.
        spuriousSet = |(req_done & ~onehot_q);
        if (doneMatch) begin
          state_d  = IDLE;
          onehot_d = 3'b000;
          cnt_d    = 8'd0;
        end else if (cnt_q == TimeoutLast) begin
          state_d    = IDLE;
          onehot_d   = 3'b000;
          cnt_d      = 8'd0;
          timeoutSet = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = 3'b000;
        cnt_d    = 8'd0;
      end
    endcase
  end

  // A set condition in the same cycle beats err_clr.
  assign illegal_d  = illegalSet  | (illegal_q  & ~err_clr);
  assign spurious_d = spuriousSet | (spurious_q & ~err_clr);
  assign timeout_d  = timeoutSet  | (timeout_q  & ~err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      onehot_q   <= 3'b000;
      cnt_q      <= 8'd0;
      illegal_q  <= 1'b0;
      spurious_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      onehot_q   <= onehot_d;
      cnt_q      <= cnt_d;
      illegal_q  <= illegal_d;
      spurious_q <= spurious_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy         = (state_q == HOLD);
  assign grant_ready  = (state_q == IDLE);
  assign grant_onehot = onehot_q;
  assign hold_cnt     = cnt_q;
  assign err_illegal  = illegal_q;
  assign err_spurious = spurious_q;
  assign err_timeout  = timeout_q;

endmodule

// File: tb/tb_grant_onehot_decoder.sv
// Directed testbench for grant_onehot_decoder with TIMEOUT=16.
// Inputs change 1 time unit after a rising edge, and outputs are sampled
// at that same point.
module tb_grant_onehot_decoder;

  logic       clk;
  logic       rst_n;
  logic       grantValid;
  logic [1:0] grantCode;
  logic       grantReady;
  logic [2:0] reqDone;
  logic [2:0] grantOnehot;
  logic       busy;
  logic [7:0] holdCnt;
  logic       errClr;
  logic       errIllegal;
  logic       errSpurious;
  logic       errTimeout;

  int totalCount = 0;
  int badCount   = 0;

  grant_onehot_decoder #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .grant_valid  (grantValid),
    .grant_code   (grantCode),
    .grant_ready  (grantReady),
    .req_done     (reqDone),
    .grant_onehot (grantOnehot),
    .busy         (busy),
    .hold_cnt     (holdCnt),
    .err_clr      (errClr),
    .err_illegal  (errIllegal),
    .err_spurious (errSpurious),
    .err_timeout  (errTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    totalCount++;
    if (obs !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkErrors(input string tag, input logic ill, input logic spu, input logic tmo);
    checkOutput({tag, "_illegal"}, 8'(errIllegal), 8'(ill));
    checkOutput({tag, "_spurious"}, 8'(errSpurious), 8'(spu));
    checkOutput({tag, "_timeout"}, 8'(errTimeout), 8'(tmo));
  endtask

  task automatic clearErrors();
    errClr = 1'b1;
    applyStimulus();
    errClr = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    grantValid = 1'b0;
    grantCode  = 2'b00;
    reqDone    = 3'b000;
    errClr     = 1'b0;

    // Reset state
    #3;
    checkOutput("rst_onehot", 8'(grantOnehot), 8'h00);
    checkOutput("rst_busy", 8'(busy), 8'h00);
    checkOutput("rst_ready", 8'(grantReady), 8'h01);
    checkOutput("rst_cnt", holdCnt, 8'h00);
    checkErrors("rst", 1'b0, 1'b0, 1'b0);
    #9;
    rst_n = 1'b1;
    applyStimulus();

    // Grant code 10, released by matching req_done after 3 held cycles
    grantValid = 1'b1;
    grantCode  = 2'b10;
    applyStimulus();
    grantValid = 1'b0;
    checkOutput("g10_onehot0", 8'(grantOnehot), 8'h02);
    checkOutput("g10_busy", 8'(busy), 8'h01);
    checkOutput("g10_ready", 8'(grantReady), 8'h00);
    checkOutput("g10_cnt0", holdCnt, 8'd0);
    applyStimulus();
    checkOutput("g10_cnt1", holdCnt, 8'd1);
    applyStimulus();
    checkOutput("g10_cnt2", holdCnt, 8'd2);
    checkOutput("g10_onehot2", 8'(grantOnehot), 8'h02);
    reqDone = 3'b010;
    applyStimulus();
    reqDone = 3'b000;
    checkOutput("g10_rel_onehot", 8'(grantOnehot), 8'h00);
    checkOutput("g10_rel_cnt", holdCnt, 8'd0);
    checkOutput("g10_rel_busy", 8'(busy), 8'h00);
    checkErrors("g10", 1'b0, 1'b0, 1'b0);

    // Back-to-back grants 01, 10, 11 with a code offered while holding
    grantValid = 1'b1;
    grantCode  = 2'b01;
    applyStimulus();
    checkOutput("b2b_01", 8'(grantOnehot), 8'h01);
    grantCode = 2'b10;
    reqDone   = 3'b001;
    applyStimulus();
    checkOutput("b2b_rel01", 8'(grantOnehot), 8'h00);
    reqDone = 3'b000;
    applyStimulus();
    checkOutput("b2b_10", 8'(grantOnehot), 8'h02);
    checkOutput("b2b_10_cnt", holdCnt, 8'd0);
    grantCode = 2'b11;
    reqDone   = 3'b010;
    applyStimulus();
    checkOutput("b2b_rel10", 8'(grantOnehot), 8'h00);
    reqDone = 3'b000;
    applyStimulus();
    grantValid = 1'b0;
    checkOutput("b2b_11", 8'(grantOnehot), 8'h04);
    reqDone = 3'b100;
    applyStimulus();
    reqDone = 3'b000;
    checkOutput("b2b_rel11", 8'(grantOnehot), 8'h00);
    checkErrors("b2b", 1'b0, 1'b0, 1'b0);

    // Illegal code 00, then clear, then set beats clear
    grantValid = 1'b1;
    grantCode  = 2'b00;
    applyStimulus();
    grantValid = 1'b0;
    checkOutput("ill_onehot", 8'(grantOnehot), 8'h00);
    checkOutput("ill_busy", 8'(busy), 8'h00);
    checkErrors("ill", 1'b1, 1'b0, 1'b0);
    clearErrors();
    checkOutput("ill_clr", 8'(errIllegal), 8'h00);
    grantValid = 1'b1;
    errClr     = 1'b1;
    applyStimulus();
    grantValid = 1'b0;
    errClr     = 1'b0;
    checkOutput("ill_prio", 8'(errIllegal), 8'h01);
    clearErrors();
    checkOutput("ill_clr2", 8'(errIllegal), 8'h00);

    // Timeout with code 11 and no release
    grantValid = 1'b1;
    grantCode  = 2'b11;
    applyStimulus();
    grantValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("tmo_onehot%0d", i), 8'(grantOnehot), 8'h04);
      checkOutput($sformatf("tmo_cnt%0d", i), holdCnt, 8'(i));
      applyStimulus();
    end
    checkOutput("tmo_rel_onehot", 8'(grantOnehot), 8'h00);
    checkOutput("tmo_rel_busy", 8'(busy), 8'h00);
    checkErrors("tmo", 1'b0, 1'b0, 1'b1);
    clearErrors();

    // Spurious release bit alongside the matching bit
    grantValid = 1'b1;
    grantCode  = 2'b01;
    applyStimulus();
    grantValid = 1'b0;
    reqDone    = 3'b011;
    applyStimulus();
    reqDone = 3'b000;
    checkOutput("spu_onehot", 8'(grantOnehot), 8'h00);
    checkErrors("spu", 1'b0, 1'b1, 1'b0);
    clearErrors();

    // Matching release on the timeout cycle wins over timeout
    grantValid = 1'b1;
    grantCode  = 2'b01;
    applyStimulus();
    grantValid = 1'b0;
    for (int i = 0; i < 15; i++) applyStimulus();
    checkOutput("race_cnt", holdCnt, 8'd15);
    checkOutput("race_onehot", 8'(grantOnehot), 8'h01);
    reqDone = 3'b001;
    applyStimulus();
    reqDone = 3'b000;
    checkOutput("race_rel", 8'(grantOnehot), 8'h00);
    checkErrors("race", 1'b0, 1'b0, 1'b0);

    // Release strobe while idle is spurious
    reqDone = 3'b100;
    applyStimulus();
    reqDone = 3'b000;
    checkErrors("idle_done", 1'b0, 1'b1, 1'b0);
    clearErrors();
    checkErrors("idle_clr", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a held grant
    grantValid = 1'b1;
    grantCode  = 2'b01;
    applyStimulus();
    grantValid = 1'b0;
    applyStimulus();
    checkOutput("ar_held", 8'(grantOnehot), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_onehot", 8'(grantOnehot), 8'h00);
    checkOutput("ar_busy", 8'(busy), 8'h00);
    checkOutput("ar_ready", 8'(grantReady), 8'h01);
    checkOutput("ar_cnt", holdCnt, 8'h00);
    checkErrors("ar", 1'b0, 1'b0, 1'b0);
    #1;
    rst_n      = 1'b1;
    grantValid = 1'b1;
    grantCode  = 2'b10;
    applyStimulus();
    grantValid = 1'b0;
    checkOutput("ar_regrant", 8'(grantOnehot), 8'h02);
    checkErrors("ar_post", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/grant_onehot_decoder.md
GRANT_ONEHOT_DECODER -- requirements
Module: grant_onehot_decoder

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum cycles a grant is held without release (legal range 2..255).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  single clock, rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: grant_valid  input  1  encoded grant offered this cycle.
REQ-006 Port: grant_code  input  2  encoded grant: 01=requester0, 10=requester1, 11=requester2, 00=illegal.
REQ-007 Port: grant_ready  output  1  block accepts a grant this cycle.
REQ-008 Port: req_done  input  3  per-requester release strobe, one bit per requester.
REQ-009 Port: grant_onehot  output  3  registered one-hot grant to requesters.
REQ-010 Port: busy  output  1  a grant is currently held.
REQ-011 Port: hold_cnt  output  8  cycles elapsed in current grant.
REQ-012 Port: err_clr  input  1  synchronous clear of sticky error flags.
REQ-013 Port: err_illegal  output  1  sticky, illegal code 00 accepted.
REQ-014 Port: err_spurious  output  1  sticky, req_done on a non-granted bit.
REQ-015 Port: err_timeout  output  1  sticky, grant forcibly released by timeout.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and HOLD; busy=1 iff state is HOLD.
REQ-017 grant_ready SHALL be 1 in IDLE and 0 in HOLD; a transfer occurs when grant_valid and grant_ready are both 1.
REQ-018 On a transfer with a legal code, the FSM SHALL move to HOLD and grant_onehot SHALL take 001/010/100 for 01/10/11 on the next rising edge (latency 1 cycle).
REQ-019 On a transfer with code 00, the FSM SHALL stay in IDLE, grant_onehot SHALL stay 000 and err_illegal SHALL set on the next edge.
REQ-020 grant_valid in HOLD SHALL be ignored (no state or output change, no error).
REQ-021 In HOLD, grant_onehot SHALL be held constant; exactly one bit is set at all times in HOLD.
REQ-022 hold_cnt SHALL be 0 in IDLE, load 0 on entry to HOLD, and increment by 1 each cycle in HOLD.
REQ-023 In HOLD, req_done bit matching the held grant SHALL return the FSM to IDLE with grant_onehot=000 and hold_cnt=0 on the next edge.
REQ-024 In HOLD, any set req_done bit not matching the held grant SHALL set err_spurious; a matching bit in the same cycle is still honoured.
REQ-025 req_done in IDLE SHALL set err_spurious if any bit is set.
REQ-026 In HOLD with hold_cnt==TIMEOUT-1 and no matching req_done, the FSM SHALL return to IDLE, clear grant_onehot and set err_timeout on the next edge.
REQ-027 Matching req_done in the same cycle as the timeout condition SHALL win: normal release, err_timeout not set.
REQ-028 A grant SHALL be accepted in the first IDLE cycle after a release (back-to-back grants separated by exactly one IDLE cycle).
REQ-029 err_clr SHALL clear all three sticky flags on the next edge; a set condition in the same cycle SHALL take priority over err_clr for that flag.
REQ-030 All outputs SHALL be registered or decoded from state only; no combinational path from inputs to outputs.

Reset
REQ-031 While rst_n=0 the block SHALL immediately force: state IDLE, grant_onehot=000, busy=0, grant_ready=1, hold_cnt=0, all error flags 0.
REQ-032 Reset asserted mid-HOLD SHALL drop the grant asynchronously without setting any error flag.
REQ-033 After rst_n deasserts, a grant SHALL be accepted on the first rising edge.

Verification
REQ-034 Code 10 with valid for one cycle, req_done=010 after 3 cycles -> grant_onehot=010 for 3 cycles, hold_cnt reaches 2, then 000, no errors.
REQ-035 Code 00 with valid in IDLE -> grant_onehot stays 000, err_illegal=1; err_clr pulse -> err_illegal=0.
REQ-036 Code 11 with TIMEOUT=16, no req_done -> grant_onehot=100 for 16 cycles, then 000 and err_timeout=1.
REQ-037 Grant 01 held, req_done=011 -> release on next edge and err_spurious=1; at hold_cnt=TIMEOUT-1 with req_done=001 -> release with err_timeout=0.
REQ-038 Grant 01 held, rst_n pulsed low mid-HOLD -> grant_onehot=000 immediately, no error flags; code 10 on first edge after reset -> grant_onehot=010.
REQ-039 Back-to-back grants 01, 10, 11 each released after 1 cycle -> each accepted one IDLE cycle after previous release; code offered in HOLD ignored.
